// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a 2-entry {pc, inst} queue and flush/discard handling
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);
  typedef enum logic {FETCH, DISCARD} state_t;
  state_t      state;
  logic [1:0]  count;
  logic [31:0] fetch_pc, hold_addr;
  logic [31:0] pc_q [2];
  logic [31:0] inst_q [2];
  logic        ack, pop, slot;
  // a request can only start while count<2 and nothing but an ack grows count, so it stays held
  assign imem_req_o  = rst && (state == DISCARD || count != 2'd2);
  assign imem_addr_o = state == DISCARD ? hold_addr : fetch_pc;
  assign ack         = imem_ack_i && imem_req_o;
  assign valid_o     = count != 2'd0;
  assign pop         = valid_o && !stall_i;
  assign slot        = count[0] && !pop;
  assign pc_o        = valid_o ? pc_q[0] : 32'h0;
  assign inst_o      = valid_o ? inst_q[0] : 32'h0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= FETCH;
      count     <= 2'd0;
      fetch_pc  <= RESET_PC;
      hold_addr <= 32'h0;
      pc_q      <= '{default: '0};
      inst_q    <= '{default: '0};
    end else if (flush_i) begin
      count    <= 2'd0;
      fetch_pc <= {new_pc_i[31:2], 2'b00};
      if (state == FETCH && imem_req_o && !ack) begin
        state     <= DISCARD;
        hold_addr <= fetch_pc;
      end else if (ack) state <= FETCH;
    end else if (state == DISCARD) begin
      if (ack) state <= FETCH;
    end else begin
      if (pop) begin
        pc_q[0]   <= pc_q[1];
        inst_q[0] <= inst_q[1];
      end
      if (ack) begin
        pc_q[slot]   <= fetch_pc;
        inst_q[slot] <= imem_rdata_i;
        fetch_pc     <= fetch_pc + 32'd4;
      end
      count <= count + {1'b0, ack} - {1'b0, pop};
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized checks of if_fetch against a queue-based reference model
module tb_if_fetch;
  logic clk = 0, rst = 0, rst2 = 0;
  logic stall_i = 0, flush_i = 0, imem_ack_i = 0, ack2 = 0;
  logic [31:0] new_pc_i = 0, imem_rdata_i = 0, rdata2 = 0;
  logic imem_req_o, valid_o, req2, valid2;
  logic [31:0] imem_addr_o, pc_o, inst_o, addr2, pc2, inst2;
  int nchk = 0, nfail = 0;
  logic [63:0] q[$];
  logic [31:0] mpc, mold;
  bit mdisc;

  if_fetch dut (.clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o));

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst(rst2), .stall_i(1'b0), .flush_i(1'b0),
    .new_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2),
    .imem_rdata_i(rdata2), .valid_o(valid2), .pc_o(pc2), .inst_o(inst2));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_9617;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ereq();
    return rst && (mdisc || q.size() < 2);
  endfunction

  function automatic logic [31:0] eaddr();
    return mdisc ? mold : mpc;
  endfunction

  task automatic mreset();
    q.delete();
    mpc = 32'h0;
    mdisc = 0;
  endtask

  task automatic step(input bit s, input bit f, input logic [31:0] np, input bit a);
    bit r, acc;
    logic [63:0] head;
    @(negedge clk);
    r = ereq();
    head = q.size() != 0 ? q[0] : 64'h0;
    stall_i = s; flush_i = f; new_pc_i = np; imem_ack_i = a;
    imem_rdata_i = r ? mem(eaddr()) : $urandom;
    chk("req", {31'h0, imem_req_o}, {31'h0, r});
    if (r) chk("addr", imem_addr_o, eaddr());
    chk("valid", {31'h0, valid_o}, {31'h0, q.size() != 0});
    chk("pc", pc_o, head[63:32]);
    chk("inst", inst_o, head[31:0]);
    @(posedge clk);
    acc = a && r;
    if (f) begin
      q.delete();
      if (!mdisc && r && !acc) begin
        mdisc = 1;
        mold = mpc;
      end else if (acc) mdisc = 0;
      mpc = {np[31:2], 2'b00};
    end else if (mdisc) begin
      if (acc) mdisc = 0;
    end else begin
      if (q.size() != 0 && !s) void'(q.pop_front());
      if (acc) begin
        q.push_back({mpc, mem(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 0;
    stall_i = 0; flush_i = 0; imem_ack_i = 0;
    #1;
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    mreset();
    @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    mreset();
    @(negedge clk);
    chk("init_req", {31'h0, imem_req_o}, 32'h0);
    chk("init_valid", {31'h0, valid_o}, 32'h0);
    chk("init_pc", pc_o, 32'h0);
    chk("init_inst", inst_o, 32'h0);
    // wrap-around from a high reset address on the second instance
    @(posedge clk);
    #1 rst2 = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wrap_req", {31'h0, req2}, 32'h1);
      chk("wrap_addr", addr2, 32'hFFFF_FFF8 + 32'(4 * k));
      if (k > 0) begin
        chk("wrap_valid", {31'h0, valid2}, 32'h1);
        chk("wrap_pc", pc2, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
        chk("wrap_inst", inst2, mem(32'hFFFF_FFF8 + 32'(4 * (k - 1))));
      end
      ack2 = 1;
      rdata2 = mem(32'hFFFF_FFF8 + 32'(4 * k));
    end
    @(negedge clk);
    ack2 = 0;
    @(posedge clk);
    #1 rst = 1;
    repeat (6) step(0, 0, 0, 1);
    do_reset();
    repeat (5) step(1, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1);
    do_reset();
    step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0103, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 1);
    step(0, 1, 32'h0000_0040, 1);
    repeat (3) step(0, 0, 0, 1);
    do_reset();
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    do_reset();
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFB, 1);
    repeat (5) step(0, 0, 0, 1);
    repeat (400) step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 2) == 0);
    do_reset();
    repeat (200) step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 1) == 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-004 stall_i  input  1  decode stage cannot accept an instruction this cycle.
REQ-005 flush_i  input  1  redirect request; discard all fetched and in-flight instructions.
REQ-006 new_pc_i  input  32  redirect target, sampled when flush_i=1.
REQ-007 imem_req_o  output  1  instruction memory read request.
REQ-008 imem_addr_o  output  32  word-aligned read address.
REQ-009 imem_ack_i  input  1  read complete; imem_rdata_i valid this cycle.
REQ-010 imem_rdata_i  input  32  instruction word.
REQ-011 valid_o  output  1  pc_o/inst_o hold a valid instruction for decode.
REQ-012 pc_o  output  32  address of presented instruction.
REQ-013 inst_o  output  32  presented instruction.

Function
REQ-014 The block SHALL hold a 2-entry FIFO of {pc, inst} pairs, count 0..2; head entry drives pc_o/inst_o.
REQ-015 valid_o SHALL equal (count!=0); when valid_o=0, pc_o and inst_o SHALL be 32'h0 (nop).
REQ-016 Pop SHALL occur on a rising edge where valid_o=1, stall_i=0 and flush_i=0.
REQ-017 The FSM SHALL have states FETCH and DISCARD; reset state FETCH.
REQ-018 In FETCH, imem_req_o SHALL be 1 iff count<2, with imem_addr_o = fetch_pc.
REQ-019 Once imem_req_o rises, it and imem_addr_o SHALL stay constant until the edge at which imem_ack_i=1 (bus rule), in both states; reset excepted.
REQ-020 imem_ack_i MAY be 1 in the first cycle imem_req_o=1; the block SHALL accept ack only when imem_req_o=1; ack with imem_req_o=0 is ignored.
REQ-021 On an accepted ack in FETCH with flush_i=0: push {fetch_pc, imem_rdata_i}; fetch_pc <= fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); valid_o rises the following cycle (fetch latency: ack edge +1).
REQ-022 Push and pop on the same edge SHALL leave count unchanged and preserve order.
REQ-023 At most one request SHALL be outstanding; no request is raised while count=2.
REQ-024 On flush_i=1: count <= 0 (flush wins over pop and push); fetch_pc <= {new_pc_i[31:2],2'b00}.
REQ-025 Flush while a request is held without ack in the same cycle: state <= DISCARD.
REQ-026 Flush with ack in the same cycle: returned data dropped, state stays FETCH, next request at new target.
REQ-027 In DISCARD: imem_req_o=1 at the old address until ack; ack data dropped, no push, fetch_pc not incremented; state <= FETCH on that edge.
REQ-028 A second flush in DISCARD SHALL update fetch_pc to the latest new_pc_i and remain in DISCARD (or return to FETCH if ack is in the same cycle).
REQ-029 stall_i SHALL NOT suppress or withdraw memory requests; fetch continues until count=2.

Reset
REQ-030 While rst=0, asynchronously: count=0, state=FETCH, fetch_pc=RESET_PC, imem_req_o=0, valid_o=0, pc_o=0, inst_o=0.
REQ-031 Reset mid-request SHALL drop imem_req_o immediately; any later ack for it is ignored per REQ-020.
REQ-032 First request SHALL be raised in the first cycle after rst deasserts, addr = RESET_PC.

Verification
REQ-033 Reset release, ack every cycle, stall_i=0 -> addresses 0,4,8,...; valid_o from 2nd cycle; pc_o/inst_o match memory 1 cycle after ack.
REQ-034 stall_i=1 for 5 cycles from start -> exactly two pushes (pc 0,4), imem_req_o=0 while count=2, head pc_o=0 held; release -> 0,4,8 delivered in order, no loss or duplicate.
REQ-035 Memory latency 3 cycles; flush_i=1 with new_pc_i=32'h0000_0103 in 2nd wait cycle -> req held at old addr until ack, data dropped, next request addr 32'h0000_0100, first valid pc_o=32'h100.
REQ-036 flush_i, ack and pop in the same cycle with count=2 -> next cycle valid_o=0, count 0, request at new target.
REQ-037 Start at RESET_PC=32'hFFFF_FFF8 -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst=0 asserted while imem_req_o=1 and count=1 -> outputs zero within same cycle; after release fetch restarts at RESET_PC.
